// File: rtl/rr_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb_pkg : shared types and helpers for the round-robin arbiter         |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package rr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  // Widest request vector the popcount helper accepts; callers zero-extend.
  localparam int MAX_REQ = 256;

  function automatic int unsigned popcount(input logic [MAX_REQ-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick  : combinational rotate-priority picker                          |
// |            scans ptr+1, ptr+2, ... modulo N, optionally skipping one idx |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          excl_en,
  input  logic [IW-1:0] excl_idx,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  oh
);

  logic [N-1:0]  masked;
  logic [IW-1:0] cand;
  int            sum;

  always_comb begin
    masked = req;
    if (excl_en) masked[excl_idx] = 1'b0;
    found = 1'b0;
    idx   = '0;
    oh    = '0;
    cand  = '0;
    sum   = 0;
    // k runs 1..N so the pointer itself is the lowest-priority candidate.
    for (int k = 1; k <= N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!found && masked[cand]) begin
        found     = 1'b1;
        idx       = cand;
        oh[cand]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter_seq : registered round-robin arbiter with grant hold, release |
// |                  and optional hold-time preemption (RR_ARB_TIMEOUT_EN)   |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module rr_arbiter_seq
  import rr_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4,
  parameter int IW       = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         reqs_i,
  input  logic                 done_i,
  output logic                 any_grant_o,
  output logic                 grant_valid_o,
  output logic [IW-1:0]        grant_idx_o,
  output logic [N-1:0]         grant_oh_o,
  output logic [$clog2(N+1)-1:0] cnt_o,
  output logic [IW-1:0]        lowp_o
);

  localparam int CW = $clog2(N+1);

  arb_state_t    state, state_nxt;
  logic          grant_valid, grant_valid_nxt;
  logic [IW-1:0] grant_idx, grant_idx_nxt;
  logic [N-1:0]  grant_oh, grant_oh_nxt;
  logic [IW-1:0] lowp, lowp_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          rel;
  logic          timeout;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;

  assign rel = (state == GRANT) && (done_i || !reqs_i[grant_idx] || timeout);

  // On release the pointer moves to the releasing index in the same cycle.
  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req      (reqs_i),
    .ptr      (rel ? grant_idx : lowp),
    .excl_en  (rel),
    .excl_idx (grant_idx),
    .found    (pick_found),
    .idx      (pick_idx),
    .oh       (pick_oh)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grant_oh    <= '0;
      lowp        <= IW'(N-1);
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_oh    <= grant_oh_nxt;
      lowp        <= lowp_nxt;
      cnt         <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (rel && !pick_found && !reqs_i[grant_idx]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_valid_nxt = grant_valid;
    grant_idx_nxt   = grant_idx;
    grant_oh_nxt    = grant_oh;
    lowp_nxt        = lowp;
    cnt_nxt         = CW'(popcount(MAX_REQ'(reqs_i)));
    if (state == IDLE) begin
      if (pick_found) begin
        grant_valid_nxt = 1'b1;
        grant_idx_nxt   = pick_idx;
        grant_oh_nxt    = pick_oh;
      end
    end else if (rel) begin
      lowp_nxt = grant_idx;
      if (pick_found) begin
        grant_idx_nxt = pick_idx;
        grant_oh_nxt  = pick_oh;
      end else if (!reqs_i[grant_idx]) begin
        grant_valid_nxt = 1'b0;
        grant_idx_nxt   = '0;
        grant_oh_nxt    = '0;
      end
      // else: sole remaining requester keeps the grant with a fresh tenure
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_cnt;

  assign timeout = (hold_cnt == HW'(MAX_HOLD-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt <= '0;
    end else if (state == IDLE || rel) begin
      hold_cnt <= '0;
    end else if (!timeout) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_max_hold;
  assign unused_max_hold = 32'(MAX_HOLD);
  assign timeout         = 1'b0;
`endif

  assign any_grant_o   = grant_valid;
  assign grant_valid_o = grant_valid;
  assign grant_idx_o   = grant_idx;
  assign grant_oh_o    = grant_oh;
  assign cnt_o         = cnt;
  assign lowp_o        = lowp;

endmodule
`default_nettype wire

// File: doc/rr_arbiter_seq.md
# rr_arbiter_seq

Registered, parametrised round-robin arbiter granting one of N requesters at a time, with grant hold, explicit release and optional hold-time preemption. Successor to the team's combinational 8-input arbiter: the low-priority pointer is now internal state, updated on each release, instead of a caller-supplied input. Sits between requesting masters and a shared resource (bus, memory port); the grant is stable for the whole tenure.

## Interface
- N, default 8: number of requesters, at least 2.
- MAX_HOLD, default 4: maximum grant tenure in cycles when timeout is compiled in, at least 1.
- IW, default $clog2(N): index width, derived; not to be overridden.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- reqs_i  in  N  request vector; bit i is requester i.
- done_i  in  1  granted requester releases the resource this cycle.
- any_grant_o  out  1  a grant is currently held; equal to grant_valid_o.
- grant_valid_o  out  1  grant_idx_o and grant_oh_o are valid.
- grant_idx_o  out  IW  binary index of the granted requester.
- grant_oh_o  out  N  one-hot grant; all zero when no grant.
- cnt_o  out  $clog2(N+1)  registered popcount of reqs_i, covering all N bits.
- lowp_o  out  IW  current lowest-priority pointer (last released index).

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if reqs_i is nonzero, pick the first set bit scanning lowp+1, lowp+2, … modulo N, wrapping. Register it into grant_idx/oh, set grant_valid, clear hold_cnt, go to GRANT. If reqs_i is zero, stay in IDLE.
- GRANT: release occurs when any of these holds:
  - done_i = 1;
  - reqs_i[grant_idx] = 0 (requester withdrew);
  - hold_cnt == MAX_HOLD-1 (timeout build only).
- On release: lowp <= grant_idx. Re-arbitrate in the same cycle with the updated pointer, excluding the releasing index. If another request exists, grant it next cycle and stay in GRANT (back-to-back, no gap). Otherwise clear the grant and go to IDLE.
- The releasing requester is granted again immediately only if it is the sole requester and did not withdraw.
- Otherwise, in GRANT: hold_cnt increments and saturates at MAX_HOLD-1; the grant is unchanged even if higher-priority requests arrive.
- Simultaneous done_i and timeout count as a single release; the pointer advances once.
- Index arithmetic is modulo N. For non-power-of-2 N, indices ≥ N are never produced.

## Timing
- Reset values:
  - state IDLE;
  - grant_valid_o, any_grant_o 0;
  - grant_idx_o 0;
  - grant_oh_o 0;
  - cnt_o 0;
  - lowp_o N-1, so requester 0 has highest priority after reset;
  - hold_cnt 0.
- Reset asserted mid-tenure drops the grant on the next edge; no release pointer update.
- Request to grant latency is 1 cycle: request sampled at edge k, grant visible after edge k+1.
- Release to next grant is 1 cycle: done_i high in cycle k, new grant visible from edge k+1.
- cnt_o reflects reqs_i sampled at the previous edge.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- RR_ARB_TIMEOUT_EN defined: hold_cnt and MAX_HOLD preemption are present. A tenure lasts at most MAX_HOLD cycles, then forced release.
- Not defined: hold_cnt is removed and MAX_HOLD is ignored. A tenure ends only on done_i or request withdrawal.

## Structure
- Package rr_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - function popcount sized by parameter (or a generic loop);
  - no N-dependent constants other than via function arguments.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, pointer, exclude-enable, exclude index.
  - Outputs: found, idx, one-hot.
  - Instantiated once in rr_arbiter_seq.

## Test plan
- Reset priority: reset, then reqs_i=8'b1111_1111 with done_i pulsed each cycle → grants 0,1,2,…,7,0 on successive cycles; lowp_o follows 0,1,2,…
- Hold and wrap: lowp=6, reqs_i=8'b0000_0011 → grant 0. Hold 3 cycles, done_i=1 → grant 1 on the next cycle. Then done → grant 0.
- Withdrawal: grant 3 held; drop reqs_i[3] while reqs_i[5]=1 → grant 5 one cycle later; lowp_o=3.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): reqs_i=8'b0000_0101, done_i never asserted → grant 0 for 4 cycles, then 2 for 4 cycles, alternating. Without the macro → grant 0 held indefinitely.
- Sole requester, count and mid-tenure reset:
  - reqs_i=8'b1000_0000 with done every cycle → grant 7 continuously;
  - cnt_o=1, and with reqs_i all ones cnt_o=8;
  - reset mid-tenure → grant_valid_o=0 and lowp_o=7 on the next cycle.
